i2s_frame_sequencer: RTL and testbench
======================================

// Module: i2s_frame_sequencer
// PURPOSE
//  Master-mode I2S controller for the sampler audio path: derives sclk/lrclk from clk,
//  serialises stereo playback words to sdout and deserialises codec sdin into stereo words.
//  Single-entry TX holding buffer with valid/ready handshake; RX frame published as a 1-cycle strobe.
//  Sits between the sample engine (clk domain) and the codec pins.
// PARAMETERS
//  SCLK_DIV  4   clk cycles per sclk period; even, >=2
//  DATA_W    24  data bits per slot, MSB-first; 1..31
// PORTS
//  clk        in   1       system clock; all logic on posedge clk
//  reset      in   1       asynchronous, active-high reset
//  enable     in   1       run request; level-sensitive
//  tx_l,tx_r  in   DATA_W  playback sample pair
//  tx_valid   in   1       tx_l/tx_r valid
//  tx_ready   out  1       holding buffer empty; transfer on tx_valid&&tx_ready
//  rx_l,rx_r  out  DATA_W  last captured sample pair
//  rx_valid   out  1       1-cycle strobe: rx_l/rx_r updated
//  underrun   out  1       1-cycle strobe: frame started with empty holding buffer
//  sclk,lrclk out  1       I2S bit clock / word select (0 = left slot)
//  sdout      out  1       serial data to codec
//  sdin       in   1       serial data from codec (pre-synchronised externally)
// BEHAVIOUR
//  Reset: sclk=0, lrclk=0, sdout=0, tx_ready=1, rx_l=rx_r=0, rx_valid=0, underrun=0, state IDLE, buffer empty.
//  Divider: div_cnt 0..SCLK_DIV-1; sclk=0 for div_cnt<SCLK_DIV/2, else 1. rise strobe at
//   div_cnt==SCLK_DIV/2-1, fall strobe at div_cnt==SCLK_DIV-1 (counter wraps to 0).
//  Frame: bit_cnt 0..63 advances on each fall strobe; lrclk = bit_cnt[5]. Slot position
//   p = bit_cnt[4:0] - D (D per CONFIGURATION). Positions 0..DATA_W-1 carry data MSB-first; all else 0.
//  FSM: IDLE -> RUN when enable=1 (div_cnt, bit_cnt start from 0). RUN -> IDLE at end of frame
//   (fall strobe with bit_cnt==63) when enable=0; current frame always completes. In IDLE sclk,
//   lrclk, sdout held 0; buffer still accepts one word.
//  TX: tx_ready = buffer empty. Accepted word sits in buffer until frame start (bit_cnt 0 begins,
//   i.e. IDLE->RUN or wrap 63->0), then loads into L/R shift regs and buffer empties same cycle.
//   Accept and load in same cycle: load the old word; new word fills buffer (tx_ready then 0).
//   Empty at frame start: shift regs load 0, underrun pulses 1 cycle. sdout updated on fall strobe.
//  RX: sdin sampled on rise strobe at positions 0..DATA_W-1 of each slot. After right-slot
//   position DATA_W-1 is sampled, rx_l/rx_r update and rx_valid pulses on the next clk cycle.
//  Latency: word accepted in frame N appears on sdout in frame N+1 (or first frame after IDLE).
//  Reset mid-frame: immediate return to reset values; partial RX frame discarded, no rx_valid.
// CONFIGURATION
//  I2S_BIT_DELAY_EN defined: D=1, Philips I2S (MSB one sclk after lrclk edge).
//  Undefined: D=0, left-justified (MSB coincides with lrclk edge).
// STRUCTURE
//  Package i2s_pkg: typedef enum {IDLE, RUN} seq_state_t; SLOT_BITS=32, FRAME_BITS=64.
//  Sub-module i2s_clk_div: div_cnt, sclk, rise/fall strobes; enable/clear input.
//  Top holds FSM, bit_cnt, TX buffer + shift regs, RX shift regs + output regs.
// TESTING (SCLK_DIV=4, DATA_W=24)
//  1 Reset asserted mid-frame -> all outputs at reset values within 1 clk; tx_ready=1.
//  2 enable=1, push tx_l=24'hA5A5A5, tx_r=24'h5A5A5A before start -> next frame sdout
//    bit-exact per D; sclk period 4 clk; lrclk toggles every 32 sclk.
//  3 Codec model loops sdout to sdin -> rx_valid one frame later, rx_l=24'hA5A5A5, rx_r=24'h5A5A5A.
//  4 No tx word at frame start -> underrun 1 cycle, slot data all 0, tx_ready stays 1.
//  5 tx_valid held high continuously -> exactly one accept per frame; words appear in order.
//  6 enable dropped at bit_cnt=10 -> frame completes to bit 63, then sclk/lrclk/sdout held 0.
//  Run 2-6 with and without I2S_BIT_DELAY_EN.

Source files
------------

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and constants for the I2S frame sequencer.
//   seq_state_t  sequencer state (IDLE / RUN)
//   SLOT_BITS    sclk periods per channel slot
//   FRAME_BITS   sclk periods per stereo frame
//   BIT_DELAY    data offset from the lrclk edge in sclk periods
// Build option: I2S_BIT_DELAY_EN defined selects Philips I2S timing, where the MSB
// follows the lrclk edge by one sclk. Undefined selects left-justified timing, where
// the MSB coincides with the lrclk edge.
package i2s_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 64;

`ifdef I2S_BIT_DELAY_EN
    localparam int BIT_DELAY = 1;
`else
    localparam int BIT_DELAY = 0;
`endif

endpackage

// File: rtl/i2s_clk_div.sv
// i2s_clk_div: derives the I2S bit clock from clk, together with single-cycle
// strobes that mark the sclk rising and falling edges.
//   clk    in   system clock
//   reset  in   asynchronous active-high reset
//   run    in   1 = count; 0 = clear the divider and hold sclk low
//   sclk   out  bit clock, low for the first half of each period
//   rise   out  strobe in the clk cycle just before sclk goes high
//   fall   out  strobe in the clk cycle just before sclk goes low (counter wraps)
module i2s_clk_div #(
    parameter int SCLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic sclk,
    output logic rise,
    output logic fall
);
    localparam int CW = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
    localparam logic [CW-1:0] HALF    = CW'(SCLK_DIV / 2);
    localparam logic [CW-1:0] HALF_M1 = CW'(SCLK_DIV / 2 - 1);
    localparam logic [CW-1:0] LAST    = CW'(SCLK_DIV - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (!run) begin
            div_cnt <= '0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    // The counter rests at 0 while stopped, so sclk is low without extra gating.
    assign sclk = (div_cnt >= HALF);
    assign rise = run && (div_cnt == HALF_M1);
    assign fall = run && (div_cnt == LAST);

endmodule

// File: rtl/i2s_frame_sequencer.sv
// i2s_frame_sequencer: master-mode I2S controller. It generates sclk and lrclk,
// serialises stereo playback words onto sdout and deserialises sdin into stereo words.
//   clk, reset          system clock, asynchronous active-high reset
//   enable              run request; the current frame always completes
//   tx_l, tx_r          playback sample pair, accepted on tx_valid && tx_ready
//   tx_ready            single-entry holding buffer is empty
//   rx_l, rx_r          last captured sample pair, qualified by the rx_valid strobe
//   underrun            strobe: a frame started with the holding buffer empty
//   sclk, lrclk, sdout  codec pins (lrclk 0 = left slot)
//   sdin                codec serial data, already synchronised to clk
// Build option: I2S_BIT_DELAY_EN (see i2s_pkg) selects Philips or left-justified timing.
module i2s_frame_sequencer
    import i2s_pkg::*;
#(
    parameter int SCLK_DIV = 4,
    parameter int DATA_W   = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] tx_l,
    input  logic [DATA_W-1:0] tx_r,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_l,
    output logic [DATA_W-1:0] rx_r,
    output logic              rx_valid,
    output logic              underrun,
    output logic              sclk,
    output logic              lrclk,
    output logic              sdout,
    input  logic              sdin
);
    localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);

    seq_state_t        state, state_nxt;
    logic              frame_start, go_idle;
    logic              sclk_rise, sclk_fall;
    logic [5:0]        bit_cnt;

    logic              buf_full;
    logic [DATA_W-1:0] buf_l, buf_r;
    logic [DATA_W-1:0] tx_l_sr, tx_r_sr;
    logic [DATA_W-1:0] ld_l, ld_r;
    logic              tx_accept;

    logic [DATA_W-1:0] rx_l_sr, rx_r_sr;
    logic [DATA_W-1:0] rx_l_shift, rx_r_shift;
    logic [5:0]        rx_pos;
    logic              rx_in_slot, rx_last;

    // Position inside the slot; bits ahead of the delayed MSB wrap to a large value
    // so a single upper-bound compare rejects them.
    function automatic logic [5:0] slot_pos(input logic [5:0] cnt);
        return {1'b0, cnt[4:0]} - 6'(BIT_DELAY);
    endfunction

    function automatic logic slot_bit(input logic [DATA_W-1:0] l,
                                      input logic [DATA_W-1:0] r,
                                      input logic [5:0]        cnt);
        logic [5:0]        p;
        logic [DATA_W-1:0] w;
        p = slot_pos(cnt);
        w = (cnt[5] ? r : l) << p;
        return (p < 6'(DATA_W)) ? w[DATA_W-1] : 1'b0;
    endfunction

    i2s_clk_div #(.SCLK_DIV(SCLK_DIV)) u_clk_div (
        .clk   (clk),
        .reset (reset),
        .run   (state == RUN),
        .sclk  (sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        go_idle     = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt   = RUN;
                    frame_start = 1'b1;
                end
            end
            RUN: begin
                if (sclk_fall && bit_cnt == LAST_BIT) begin
                    if (enable) begin
                        frame_start = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        go_idle   = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign tx_ready  = !buf_full;
    assign tx_accept = tx_valid && !buf_full;
    assign ld_l      = buf_full ? buf_l : '0;
    assign ld_r      = buf_full ? buf_r : '0;
    assign lrclk     = bit_cnt[5];

    assign rx_pos     = slot_pos(bit_cnt);
    assign rx_in_slot = (rx_pos < 6'(DATA_W));
    assign rx_last    = bit_cnt[5] && (rx_pos == 6'(DATA_W - 1));
    assign rx_l_shift = (rx_l_sr << 1) | DATA_W'(sdin);
    assign rx_r_shift = (rx_r_sr << 1) | DATA_W'(sdin);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt  <= '0;
            buf_full <= 1'b0;
            buf_l    <= '0;
            buf_r    <= '0;
            tx_l_sr  <= '0;
            tx_r_sr  <= '0;
            sdout    <= 1'b0;
            underrun <= 1'b0;
            rx_l_sr  <= '0;
            rx_r_sr  <= '0;
            rx_l     <= '0;
            rx_r     <= '0;
            rx_valid <= 1'b0;
        end else begin
            underrun <= 1'b0;
            rx_valid <= 1'b0;

            // Leaving RUN happens on the bit-63 fall, so the increment wraps to 0.
            if (frame_start) begin
                bit_cnt <= '0;
            end else if (sclk_fall) begin
                bit_cnt <= bit_cnt + 6'd1;
            end

            // A word accepted on the load cycle lands behind the word being loaded.
            if (tx_accept) begin
                buf_full <= 1'b1;
                buf_l    <= tx_l;
                buf_r    <= tx_r;
            end else if (frame_start) begin
                buf_full <= 1'b0;
            end

            // sdout is registered one bit ahead: each fall presents the next bit.
            if (frame_start) begin
                tx_l_sr  <= ld_l;
                tx_r_sr  <= ld_r;
                underrun <= !buf_full;
                sdout    <= slot_bit(ld_l, ld_r, 6'd0);
            end else if (go_idle) begin
                sdout <= 1'b0;
            end else if (sclk_fall) begin
                sdout <= slot_bit(tx_l_sr, tx_r_sr, bit_cnt + 6'd1);
            end

            if (sclk_rise && rx_in_slot) begin
                if (!bit_cnt[5]) begin
                    rx_l_sr <= rx_l_shift;
                end else begin
                    rx_r_sr <= rx_r_shift;
                end
                if (rx_last) begin
                    rx_l     <= rx_l_sr;
                    rx_r     <= rx_r_shift;
                    rx_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_frame_sequencer.sv
// tb_i2s_frame_sequencer: directed bench for i2s_frame_sequencer (SCLK_DIV=4, DATA_W=24)
// with sdout looped back to sdin. Build with or without I2S_BIT_DELAY_EN.
module tb_i2s_frame_sequencer;

`ifdef I2S_BIT_DELAY_EN
    localparam int D = 1;
`else
    localparam int D = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [23:0] tx_l = '0;
    logic [23:0] tx_r = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [23:0] rx_l, rx_r;
    logic        rx_valid, underrun, sclk, lrclk, sdout, sdin;

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] wl [3] = '{24'h123456, 24'hFEDCBA, 24'h0F0F0F};
    logic [23:0] wr [3] = '{24'h654321, 24'h800001, 24'hC3C3C3};
    int          widx = 0;
    logic        stream_on = 1'b0;

    i2s_frame_sequencer #(.SCLK_DIV(4), .DATA_W(24)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .tx_l     (tx_l),
        .tx_r     (tx_r),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_l     (rx_l),
        .rx_r     (rx_r),
        .rx_valid (rx_valid),
        .underrun (underrun),
        .sclk     (sclk),
        .lrclk    (lrclk),
        .sdout    (sdout),
        .sdin     (sdin)
    );

    assign sdin = sdout;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_bit(input logic [23:0] l, input logic [23:0] r, input int b);
        int          pos;
        logic [23:0] w;
        w   = (b >= 32) ? r : l;
        pos = (b % 32) - D;
        if (pos < 0 || pos > 23) return 1'b0;
        w = w << pos;
        return w[23];
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, " sclk"},     32'(sclk),     32'd0);
        check_eq({tag, " lrclk"},    32'(lrclk),    32'd0);
        check_eq({tag, " sdout"},    32'(sdout),    32'd0);
        check_eq({tag, " tx_ready"}, 32'(tx_ready), 32'd1);
        check_eq({tag, " rx_valid"}, 32'(rx_valid), 32'd0);
        check_eq({tag, " underrun"}, 32'(underrun), 32'd0);
        check_eq({tag, " rx_l"},     32'(rx_l),     32'd0);
        check_eq({tag, " rx_r"},     32'(rx_r),     32'd0);
    endtask

    // Called just after the clk edge that starts a frame; returns just after the
    // edge that ends it.
    task automatic run_frame(input int fno, input logic [23:0] el, input logic [23:0] er,
                             input logic exp_ur, input logic start_stream,
                             input logic drop_en, input int exp_acc);
        int   rx_seen;
        int   accepts;
        logic acc;
        rx_seen = 0;
        accepts = 0;
        for (int b = 0; b < 64; b++) begin
            for (int k = 0; k < 4; k++) begin
                check_eq($sformatf("f%0d b%0d k%0d sclk", fno, b, k), 32'(sclk), 32'(k >= 2));
                check_eq($sformatf("f%0d b%0d k%0d lrclk", fno, b, k), 32'(lrclk), 32'(b >= 32));
                check_eq($sformatf("f%0d b%0d k%0d sdout", fno, b, k), 32'(sdout),
                         32'(exp_bit(el, er, b)));
                check_eq($sformatf("f%0d b%0d k%0d underrun", fno, b, k), 32'(underrun),
                         32'(exp_ur && b == 0 && k == 0));
                if (b == 0 && k == 0)
                    check_eq($sformatf("f%0d tx_ready at start", fno), 32'(tx_ready), 32'd1);
                if (rx_valid) begin
                    rx_seen++;
                    check_eq($sformatf("f%0d rx_pos", fno), 32'(b * 4 + k), 32'((55 + D) * 4 + 2));
                    check_eq($sformatf("f%0d rx_l", fno), 32'(rx_l), 32'(el));
                    check_eq($sformatf("f%0d rx_r", fno), 32'(rx_r), 32'(er));
                end
                if (b == 10 && k == 0) begin
                    if (start_stream) begin
                        stream_on = 1'b1;
                        widx      = 0;
                        tx_valid  = 1'b1;
                        tx_l      = wl[0];
                        tx_r      = wr[0];
                    end
                    if (drop_en) enable = 1'b0;
                end
                acc = stream_on && tx_ready;
                tick();
                if (acc) begin
                    accepts++;
                    widx++;
                    if (widx < 3) begin
                        tx_l = wl[widx];
                        tx_r = wr[widx];
                    end else begin
                        tx_valid  = 1'b0;
                        stream_on = 1'b0;
                    end
                end
            end
        end
        check_eq($sformatf("f%0d rx_valid count", fno), 32'(rx_seen), 32'd1);
        check_eq($sformatf("f%0d accept count", fno), 32'(accepts), 32'(exp_acc));
    endtask

    initial begin
        #12;
        check_reset_outputs("in reset");
        reset = 1'b0;
        tick();
        check_reset_outputs("after reset");

        // One word queued before the sequencer starts.
        tx_l     = 24'hA5A5A5;
        tx_r     = 24'h5A5A5A;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check_eq("tx_ready after push", 32'(tx_ready), 32'd0);
        check_eq("sclk idle before enable", 32'(sclk), 32'd0);
        enable = 1'b1;
        tick();

        run_frame(1, 24'hA5A5A5, 24'h5A5A5A, 1'b0, 1'b0, 1'b0, 0);
        run_frame(2, 24'h000000, 24'h000000, 1'b1, 1'b1, 1'b0, 1);
        run_frame(3, wl[0], wr[0], 1'b0, 1'b0, 1'b0, 1);
        run_frame(4, wl[1], wr[1], 1'b0, 1'b0, 1'b1, 1);

        for (int i = 0; i < 40; i++) begin
            check_eq($sformatf("idle %0d sclk", i), 32'(sclk), 32'd0);
            check_eq($sformatf("idle %0d lrclk", i), 32'(lrclk), 32'd0);
            check_eq($sformatf("idle %0d sdout", i), 32'(sdout), 32'd0);
            check_eq($sformatf("idle %0d rx_valid", i), 32'(rx_valid), 32'd0);
            tick();
        end

        // Restart, fill the buffer, then reset part way through the frame.
        enable = 1'b1;
        tick();
        tx_l     = wl[0];
        tx_r     = wr[0];
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        repeat (158) tick();
        check_eq("pre-reset tx_ready", 32'(tx_ready), 32'd0);
        check_eq("pre-reset rx_l", 32'(rx_l), 32'(wl[1]));
        check_eq("pre-reset lrclk", 32'(lrclk), 32'd1);
        reset = 1'b1;
        #2;
        check_reset_outputs("mid-frame reset");
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq($sformatf("held reset %0d rx_valid", i), 32'(rx_valid), 32'd0);
            check_eq($sformatf("held reset %0d sclk", i), 32'(sclk), 32'd0);
        end
        reset = 1'b0;
        tick();
        tick();
        check_reset_outputs("after second reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
